hazard_ctrl: RTL and testbench

//  Pipeline stall/flush sequencer for the 5-stage core; sits beside forward_ctrl.

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer for the 5-stage core
//
// Resolves the hazards forwarding cannot cover: load-use, multi-cycle mul/div
// occupancy, data-memory wait and taken-branch squash.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_rs/id_rt, id_use_rs/rt      source registers of the ID instruction
//   ex_reg, ex_write, ex_is_load   destination info of the EX instruction
//   ex_mdu_start                   mul/div entering EX (one-cycle pulse)
//   ex_br_taken                    branch/jump in EX resolved taken
//   dmem_req, dmem_ready           data-memory handshake of the MEM stage
//   cnt_clr                        synchronous clear of stall_cycles
//   stall_if/id/ex/mem             hold enables for PC and pipeline registers
//   bubble_ex, bubble_mem, flush_id  nop insertion into ID/EX, EX/MEM, IF/ID
//   mdu_busy, mdu_done             mul/div sequencing status
//   stall_cycles                   saturating count of cycles with stall_if=1
module hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_reg,
    input  logic             ex_write,
    input  logic             ex_is_load,
    input  logic             ex_mdu_start,
    input  logic             ex_br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             bubble_ex,
    output logic             bubble_mem,
    output logic             flush_id,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, MDU_BUSY} state_t;

    state_t          state;
    logic [MW-1:0]   mdu_cnt;
    logic            freeze;
    logic            load_use;

    assign freeze = dmem_req & ~dmem_ready;

    assign load_use = ex_is_load & ex_write & (ex_reg != 5'd0) &
                      ((id_use_rs & (id_rs == ex_reg)) |
                       (id_use_rt & (id_rt == ex_reg)));

    assign mdu_busy = (state == MDU_BUSY);

    // Priority: freeze > MDU (issue or busy) > branch squash > load-use.
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        stall_mem  = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        flush_id   = 1'b0;
        mdu_done   = 1'b0;
        if (freeze) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (state == MDU_BUSY || ex_mdu_start) begin
            // The mul/div sits in EX; later stages drain behind a bubble.
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
            mdu_done   = (state == MDU_BUSY) && (mdu_cnt == '0);
        end else if (ex_br_taken) begin
            // The ID instruction is squashed, so its load-use must not stall.
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // mdu_cnt counts the remaining busy cycles after the current one, so the
    // issue cycle plus MDU_LAT-1 busy cycles give MDU_LAT stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else if (!freeze) begin
            case (state)
                RUN: begin
                    if (ex_mdu_start) begin
                        mdu_cnt <= MW'(MDU_LAT - 2);
                        state   <= MDU_BUSY;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt != '0) begin
                        mdu_cnt <= mdu_cnt - 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if (stall_if && stall_cycles != CNT_MAX) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_reg;
    logic       id_use_rs, id_use_rt, ex_write, ex_is_load;
    logic       ex_mdu_start, ex_br_taken, dmem_req, dmem_ready, cnt_clr;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       bubble_ex, bubble_mem, flush_id, mdu_busy, mdu_done;
    logic [2:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, flush_id, mdu_busy, mdu_done}
    localparam logic [8:0] O_IDLE = 9'b000_000_000;
    localparam logic [8:0] O_LU   = 9'b110_010_000;
    localparam logic [8:0] O_BR   = 9'b000_010_100;
    localparam logic [8:0] O_ISS  = 9'b111_001_000;
    localparam logic [8:0] O_BUSY = 9'b111_001_010;
    localparam logic [8:0] O_DONE = 9'b111_001_011;
    localparam logic [8:0] O_FRZ  = 9'b111_100_000;
    localparam logic [8:0] O_FRZB = 9'b111_100_010;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_reg(ex_reg), .ex_write(ex_write), .ex_is_load(ex_is_load),
        .ex_mdu_start(ex_mdu_start), .ex_br_taken(ex_br_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .flush_id(flush_id),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_reg = 0; ex_write = 0; ex_is_load = 0;
        ex_mdu_start = 0; ex_br_taken = 0;
        dmem_req = 0; dmem_ready = 0; cnt_clr = 0;
    endtask

    task automatic load_in_ex(input logic [4:0] r);
        ex_reg = r; ex_write = 1; ex_is_load = 1;
    endtask

    // Expectation is queued when stimulus is applied; the DUT response is
    // taken at the following falling edge and matched against the queue head.
    task automatic expect_outs(input string tag, input logic [8:0] e);
        logic [8:0] obs, exp_v;
        string      t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        obs   = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem,
                 flush_id, mdu_busy, mdu_done};
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", t, obs, exp_v);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [2:0] e);
        total++;
        assert (stall_cycles === e) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, stall_cycles, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag, input logic [8:0] e);
        expect_outs(tag, e);
        tick();
    endtask

    task automatic clear_cnt();
        idle();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick();
        tick();
        expect_outs("reset_outs", O_IDLE);
        check_cnt("reset_cnt", 3'd0);
        tick();
        rst_n = 1;
        tick();

        // Load-use on rs, then the stall clears once inputs go idle.
        load_in_ex(5'd5); id_rs = 5'd5; id_use_rs = 1;
        cycle("lu_rs", O_LU);
        idle();
        expect_outs("lu_after", O_IDLE);
        check_cnt("lu_cnt", 3'd1);
        tick();

        load_in_ex(5'd0); id_rs = 5'd0; id_use_rs = 1;
        cycle("lu_r0", O_IDLE);
        load_in_ex(5'd5); id_rs = 5'd5; id_use_rs = 0;
        cycle("lu_nouse", O_IDLE);
        idle();
        load_in_ex(5'd7); id_rt = 5'd7; id_use_rt = 1;
        cycle("lu_rt", O_LU);
        ex_write = 0;
        cycle("lu_nowrite", O_IDLE);

        // Taken branch overrides load-use.
        idle();
        load_in_ex(5'd9); id_rs = 5'd9; id_use_rs = 1; ex_br_taken = 1;
        cycle("br_over_lu", O_BR);

        // Memory access completing this cycle does not freeze.
        idle();
        dmem_req = 1; dmem_ready = 1;
        cycle("dmem_ready", O_IDLE);

        // MDU op: 4 stall cycles, branch and repeat start ignored.
        clear_cnt();
        ex_mdu_start = 1; ex_br_taken = 1;
        cycle("mdu_issue", O_ISS);
        ex_br_taken = 0;
        cycle("mdu_busy1", O_BUSY);
        ex_mdu_start = 0;
        cycle("mdu_busy2", O_BUSY);
        cycle("mdu_done", O_DONE);
        expect_outs("mdu_run", O_IDLE);
        check_cnt("mdu_cnt4", 3'd4);
        tick();

        // MDU op with 3-cycle memory freeze mid-op: 7 stall cycles total.
        clear_cnt();
        ex_mdu_start = 1;
        cycle("frz_issue", O_ISS);
        ex_mdu_start = 0;
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) cycle($sformatf("frz_hold%0d", i), O_FRZB);
        dmem_req = 0;
        cycle("frz_busy1", O_BUSY);
        cycle("frz_busy2", O_BUSY);
        cycle("frz_done", O_DONE);
        expect_outs("frz_run", O_IDLE);
        check_cnt("frz_cnt7", 3'd7);
        tick();

        // Two more stalls (9 total since clear) saturate at 7.
        load_in_ex(5'd3); id_rs = 5'd3; id_use_rs = 1;
        cycle("sat_lu1", O_LU);
        cycle("sat_lu2", O_LU);
        idle();
        expect_outs("sat_idle", O_IDLE);
        check_cnt("sat_cnt", 3'd7);
        tick();

        // Freeze in RUN with no MDU activity.
        dmem_req = 1;
        cycle("frz_run_only", O_FRZ);

        // Clear wins over a concurrent stall increment.
        idle();
        load_in_ex(5'd3); id_rs = 5'd3; id_use_rs = 1; cnt_clr = 1;
        cycle("clr_lu", O_LU);
        idle();
        expect_outs("clr_idle", O_IDLE);
        check_cnt("clr_cnt", 3'd0);
        tick();

        // Asynchronous reset in the middle of an MDU op.
        ex_mdu_start = 1;
        cycle("rst_issue", O_ISS);
        ex_mdu_start = 0;
        rst_n = 0;
        #1;
        total++;
        assert (mdu_busy === 1'b0) else begin
            bad++;
            $error("FAIL rst_busy: observed=%b expected=0", mdu_busy);
        end
        check_cnt("rst_cnt", 3'd0);
        expect_outs("rst_outs", O_IDLE);
        tick();
        rst_n = 1;
        cycle("rst_after", O_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
